// File: rtl/cache_line_arbiter_if.sv
// Bundles the icache, dcache and cacheline-adaptor miss-path signals shared by the arbiter.
// The master modport is the arbiter's view; slave is the view of the caches and the adaptor around it.
interface cache_line_arbiter_if #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
);
    logic                  i_pmem_read;
    logic [ADDR_WIDTH-1:0] i_pmem_address;
    logic [LINE_WIDTH-1:0] i_pmem_rdata;
    logic                  i_pmem_resp;

    logic                  d_pmem_read;
    logic                  d_pmem_write;
    logic [ADDR_WIDTH-1:0] d_pmem_address;
    logic [LINE_WIDTH-1:0] d_pmem_wdata;
    logic [LINE_WIDTH-1:0] d_pmem_rdata;
    logic                  d_pmem_resp;

    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [LINE_WIDTH-1:0] mem_wdata;
    logic [LINE_WIDTH-1:0] mem_rdata;
    logic                  mem_resp;

    modport master (
        input  i_pmem_read, i_pmem_address,
        output i_pmem_rdata, i_pmem_resp,
        input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        output d_pmem_rdata, d_pmem_resp,
        output mem_read, mem_write, mem_address, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport slave (
        output i_pmem_read, i_pmem_address,
        input  i_pmem_rdata, i_pmem_resp,
        output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        input  d_pmem_rdata, d_pmem_resp,
        input  mem_read, mem_write, mem_address, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/cache_line_arbiter.sv
// Shares one cacheline-adaptor port between icache fills and dcache fills/writebacks, one whole line at a time.
// Latency: grant drives memory 1 cycle after the request; resp passes through combinationally; 1 idle cycle after each resp.
// Backpressure: a loser simply keeps its request high until granted. Define ARB_ROUND_ROBIN_EN for alternating priority.
module cache_line_arbiter #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_line_arbiter_if.master bus
);
    localparam logic [LINE_WIDTH-1:0] LINE_ZERO = '0;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   d_req;
    logic   prefer_i;

    assign d_req = bus.d_pmem_read | bus.d_pmem_write;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d;

    // Remember who was granted last so a contested IDLE goes to the other side.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_d <= 1'b0;
        end else if (state == IDLE && state_nxt == SERVE_D) begin
            last_d <= 1'b1;
        end else if (state == IDLE && state_nxt == SERVE_I) begin
            last_d <= 1'b0;
        end
    end

    assign prefer_i = last_d;
`else
    assign prefer_i = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (d_req && !(bus.i_pmem_read && prefer_i)) begin
                    state_nxt = SERVE_D;
                end else if (bus.i_pmem_read) begin
                    state_nxt = SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                // A grant only ends on the adaptor's resp; a dropped request does not abort it.
                if (bus.mem_resp) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_read     = 1'b0;
        bus.mem_write    = 1'b0;
        bus.mem_address  = ADDR_ZERO;
        bus.mem_wdata    = LINE_ZERO;
        bus.i_pmem_rdata = LINE_ZERO;
        bus.i_pmem_resp  = 1'b0;
        bus.d_pmem_rdata = LINE_ZERO;
        bus.d_pmem_resp  = 1'b0;
        unique case (state)
            SERVE_I: begin
                bus.mem_read     = bus.i_pmem_read;
                bus.mem_address  = bus.i_pmem_address;
                bus.i_pmem_rdata = bus.mem_rdata;
                bus.i_pmem_resp  = bus.mem_resp;
            end
            SERVE_D: begin
                // Read and write together is resolved as a writeback.
                bus.mem_read     = bus.d_pmem_read & ~bus.d_pmem_write;
                bus.mem_write    = bus.d_pmem_write;
                bus.mem_address  = bus.d_pmem_address;
                bus.mem_wdata    = bus.d_pmem_wdata;
                bus.d_pmem_rdata = bus.mem_rdata;
                bus.d_pmem_resp  = bus.mem_resp;
            end
            default: ;
        endcase
    end

    d_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(bus.d_pmem_read && bus.d_pmem_write));

endmodule

// File: tb/tb_cache_line_arbiter.sv
// Randomized scoreboard bench: stimulus pushes the predicted grant order, a negedge monitor checks the adaptor side.
// Includes directed reset, lone fill, contention, back-to-back and mid-transaction reset scenarios.
module tb_cache_line_arbiter;
    localparam int LW = 256;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_line_arbiter_if #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) bus ();
    cache_line_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit            who_d;
        bit            wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        int            start;   // -1: two cycles after the previous resp
    } txn_t;

    txn_t expq[$];
    bit   mon_en      = 1'b0;
    bit   model_last_d = 1'b0;

    function automatic void tally(string name, bit ok, string got, string want);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %s want %s", name, got, want);
        end
    endfunction

    function automatic void chk1(string name, logic got, logic want);
        tally(name, got === want, $sformatf("%b", got), $sformatf("%b", want));
    endfunction

    function automatic void chka(string name, logic [AW-1:0] got, logic [AW-1:0] want);
        tally(name, got === want, $sformatf("%h", got), $sformatf("%h", want));
    endfunction

    function automatic void chkw(string name, logic [LW-1:0] got, logic [LW-1:0] want);
        tally(name, got === want, $sformatf("%h", got), $sformatf("%h", want));
    endfunction

    function automatic void chki(string name, int got, int want);
        tally(name, got == want, $sformatf("%0d", got), $sformatf("%0d", want));
    endfunction

    // Monitor: one transaction per rising edge of mem activity, checked against the queue head.
    bit   prev_act  = 1'b0;
    bit   busy      = 1'b0;
    int   last_resp = -100;
    txn_t cur;
    always @(negedge clk) begin
        logic act;
        act = bus.mem_read | bus.mem_write;
        if (!mon_en) begin
            busy     = 1'b0;
            prev_act = act;
        end else begin
            chk1("rd_wr_overlap", bus.mem_read & bus.mem_write, 1'b0);
            if (act && !prev_act) begin
                if (expq.size() == 0) begin
                    chk1("unexpected_grant", act, 1'b0);
                end else begin
                    cur  = expq.pop_front();
                    busy = 1'b1;
                    chki("grant_cycle", cyc, (cur.start >= 0) ? cur.start : last_resp + 2);
                    chk1("grant_write", bus.mem_write, cur.wr);
                    chk1("grant_read", bus.mem_read, !cur.wr);
                    chkw("grant_wdata", bus.mem_wdata, cur.who_d ? cur.wdata : {LW{1'b0}});
                end
            end else if (act && !busy) begin
                chk1("missing_idle_gap", act, 1'b0);
            end
            if (busy) begin
                chka("hold_addr", bus.mem_address, cur.addr);
                chkw("owner_rdata", cur.who_d ? bus.d_pmem_rdata : bus.i_pmem_rdata, bus.mem_rdata);
                chk1("owner_resp", cur.who_d ? bus.d_pmem_resp : bus.i_pmem_resp, bus.mem_resp);
                chk1("other_resp", cur.who_d ? bus.i_pmem_resp : bus.d_pmem_resp, 1'b0);
                chkw("other_rdata", cur.who_d ? bus.i_pmem_rdata : bus.d_pmem_rdata, {LW{1'b0}});
                if (bus.mem_resp) begin
                    last_resp = cyc;
                    busy      = 1'b0;
                end
            end else begin
                chk1("idle_i_resp", bus.i_pmem_resp, 1'b0);
                chk1("idle_d_resp", bus.d_pmem_resp, 1'b0);
            end
            prev_act = act;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic void push(bit who_d, bit wr, logic [AW-1:0] a, logic [LW-1:0] wd, int start);
        txn_t t;
        t.who_d = who_d;
        t.wr    = wr;
        t.addr  = a;
        t.wdata = wd;
        t.start = start;
        expq.push_back(t);
    endfunction

    // Reference: single requester wins; on contention dcache wins unless alternation says icache.
    function automatic void predict(bit ri, bit rd, bit dw, logic [AW-1:0] ia, logic [AW-1:0] da,
                                    logic [LW-1:0] wd, int c);
        bit i_first;
`ifdef ARB_ROUND_ROBIN_EN
        i_first = model_last_d;
`else
        i_first = 1'b0;
`endif
        if (ri && rd) begin
            if (i_first) begin
                push(1'b0, 1'b0, ia, wd, c + 1);
                push(1'b1, dw, da, wd, -1);
                model_last_d = 1'b1;
            end else begin
                push(1'b1, dw, da, wd, c + 1);
                push(1'b0, 1'b0, ia, wd, -1);
                model_last_d = 1'b0;
            end
        end else if (ri) begin
            push(1'b0, 1'b0, ia, wd, c + 1);
            model_last_d = 1'b0;
        end else if (rd) begin
            push(1'b1, dw, da, wd, c + 1);
            model_last_d = 1'b1;
        end
    endfunction

    // Drives both caches and the adaptor for one round of up to two contending requests.
    task automatic run_round(input bit ri, input bit rd, input bit dw,
                             input logic [AW-1:0] ia, input logic [AW-1:0] da,
                             input logic [LW-1:0] wd, input logic [LW-1:0] rdv0,
                             input logic [LW-1:0] rdv1, input int gap, input int dly0, input int dly1);
        int k;
        int n;
        bit gi;
        bit gd;
        for (int g = 0; g < gap; g++) begin
            bus.mem_resp = ($urandom_range(0, 2) == 0);
            step();
            bus.mem_resp = 1'b0;
        end
        bus.i_pmem_read    = ri;
        bus.i_pmem_address = ia;
        bus.d_pmem_read    = rd & ~dw;
        bus.d_pmem_write   = rd & dw;
        bus.d_pmem_address = da;
        bus.d_pmem_wdata   = wd;
        predict(ri, rd, dw, ia, da, wd, cyc);
        n = int'(ri) + int'(rd);
        for (int t = 0; t < n; t++) begin
            k = 0;
            step();
            while (!(bus.mem_read || bus.mem_write) && k < 20) begin
                step();
                k++;
            end
            if (k >= 20) begin
                chki("grant_timeout", k, 0);
                bus.i_pmem_read  = 1'b0;
                bus.d_pmem_read  = 1'b0;
                bus.d_pmem_write = 1'b0;
                expq.delete();
                break;
            end
            repeat ((t == 0) ? dly0 : dly1) step();
            bus.mem_rdata = (t == 0) ? rdv0 : rdv1;
            bus.mem_resp  = 1'b1;
            #1;
            gi = bus.i_pmem_resp;
            gd = bus.d_pmem_resp;
            step();
            bus.mem_resp  = 1'b0;
            bus.mem_rdata = rand_line();
            if (gi || !(gi || gd)) bus.i_pmem_read = 1'b0;
            if (gd || !(gi || gd)) begin
                bus.d_pmem_read  = 1'b0;
                bus.d_pmem_write = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rb;
        bit db;
        int kind;
        rst                = 1'b1;
        bus.i_pmem_read    = 1'b0;
        bus.i_pmem_address = '0;
        bus.d_pmem_read    = 1'b0;
        bus.d_pmem_write   = 1'b0;
        bus.d_pmem_address = '0;
        bus.d_pmem_wdata   = '0;
        bus.mem_rdata      = '0;
        bus.mem_resp       = 1'b0;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1("reset_mem_read", bus.mem_read, 1'b0);
            chk1("reset_mem_write", bus.mem_write, 1'b0);
            chk1("reset_i_resp", bus.i_pmem_resp, 1'b0);
            chk1("reset_d_resp", bus.d_pmem_resp, 1'b0);
            chka("reset_mem_address", bus.mem_address, '0);
            step();
        end
        mon_en = 1'b1;

        run_round(1'b1, 1'b0, 1'b0, 32'h0000_0060, 32'h0, rand_line(), {32{8'hA5}}, '0, 0, 4, 0);
        run_round(1'b1, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0200, {8{32'h1234_5678}},
                  rand_line(), rand_line(), 1, 2, 2);
        run_round(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0240, rand_line(), rand_line(), '0, 1, 1, 0);
        run_round(1'b1, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0200, {8{32'h1234_5678}},
                  rand_line(), rand_line(), 1, 1, 3);
        run_round(1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0300, rand_line(), rand_line(), '0, 1, 1, 0);
        run_round(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0300, rand_line(), rand_line(), '0, 0, 2, 0);
        for (int r = 0; r < 3; r++) begin
            run_round(1'b1, 1'b1, r[0], 32'h0000_1000 + 32'(r * 32), 32'h0000_2000 + 32'(r * 32),
                      rand_line(), rand_line(), rand_line(), 0, 0, 0);
        end

        for (int r = 0; r < 40; r++) begin
            kind = $urandom_range(0, 2);
            rb   = (kind != 1);
            db   = (kind != 0);
            run_round(rb, db, 1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFE0,
                      $urandom() & 32'hFFFF_FFE0, rand_line(), rand_line(), rand_line(),
                      $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 4));
        end

        // Reset landing in the middle of a writeback abandons it.
        step();
        mon_en             = 1'b0;
        bus.d_pmem_write   = 1'b1;
        bus.d_pmem_address = 32'h0000_0400;
        bus.d_pmem_wdata   = rand_line();
        step();
        @(negedge clk);
        chk1("midrst_write_granted", bus.mem_write, 1'b1);
        step();
        step();
        rst = 1'b1;
        step();
        bus.mem_resp = 1'b1;
        @(negedge clk);
        chk1("midrst_mem_write", bus.mem_write, 1'b0);
        chka("midrst_mem_address", bus.mem_address, '0);
        chkw("midrst_mem_wdata", bus.mem_wdata, '0);
        chk1("midrst_d_resp", bus.d_pmem_resp, 1'b0);
        step();
        rst              = 1'b0;
        bus.mem_resp     = 1'b0;
        bus.d_pmem_write = 1'b0;
        step();
        @(negedge clk);
        chk1("postrst_mem_write", bus.mem_write, 1'b0);
        chk1("postrst_mem_read", bus.mem_read, 1'b0);
        step();
        model_last_d = 1'b0;
        mon_en       = 1'b1;

        run_round(1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h0000_0600, rand_line(),
                  rand_line(), rand_line(), 1, 1, 1);
        step();
        step();
        chki("scoreboard_drain", expq.size(), 0);
        chk1("monitor_idle", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
